switch_config_loader: RTL and testbench

SWITCH_CONFIG_LOADER -- requirements
Module: switch_config_loader

---
 rtl/switch_config_loader.sv | 112 +++++++++++
 tb/tb_switch_config_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_config_loader.sv
// Serial loader for a switch-box configuration frame: shifts a frame into a shadow
// register, validates every word, then commits it to cfg_bus. Optional macro: PARITY_CHECK_EN.
module switch_config_loader #(
   parameter int W_TB   = 5,
   parameter int W_LR   = 4,
   parameter int WORD_W = 6
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      cfg_start,
   input  logic                                      cfg_din,
   input  logic                                      cfg_valid,
   input  logic                                      cfg_clear,
   output logic [(2*W_TB+2*W_LR)*WORD_W-1:0]         cfg_bus,
   output logic                                      cfg_busy,
   output logic                                      cfg_done,
   output logic                                      cfg_err
);
   // state | meaning
   // IDLE  | waiting for cfg_start; cfg_clear zeroes the active config
   // LOAD  | shifting accepted frame bits into the shadow register
   // CHECK | one cycle: validate shadow, commit or reject on exit

   localparam int NWORDS = 2*W_TB + 2*W_LR;
   localparam int TOTAL  = NWORDS*WORD_W;
`ifdef PARITY_CHECK_EN
   localparam int FRAME  = TOTAL + 1;
`else
   localparam int FRAME  = TOTAL;
`endif
   localparam int CNT_W  = $clog2(FRAME + 1);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [FRAME-1:0] shadow;
   logic [TOTAL-1:0] frame_data;
   logic             frame_bad;
   logic             last_bit;

   // With parity enabled the trailing parity bit sits at shadow[0], below the data.
   assign frame_data = shadow[FRAME-1 -: TOTAL];
   assign last_bit   = cfg_valid && (cnt == CNT_W'(FRAME-1));

   always_comb begin
      frame_bad = 1'b0;
      for (int k = 0; k < NWORDS; k++) begin
         case (frame_data[k*WORD_W +: 3])
            3'd1, 3'd3: if (int'(frame_data[k*WORD_W+3 +: 3]) >= W_TB) frame_bad = 1'b1;
            3'd2, 3'd4: if (int'(frame_data[k*WORD_W+3 +: 3]) >= W_LR) frame_bad = 1'b1;
            3'd5, 3'd6, 3'd7: frame_bad = 1'b1;
            default: ;
         endcase
      end
`ifdef PARITY_CHECK_EN
      if (^shadow) frame_bad = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         shadow   <= '0;
         cfg_bus  <= '0;
         cfg_busy <= 1'b0;
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_clear) begin
                  cfg_bus <= '0;
               end else if (cfg_start) begin
                  state    <= LOAD;
                  cnt      <= '0;
                  shadow   <= '0;
                  cfg_busy <= 1'b1;
               end
            end
            LOAD: begin
               // A restart discards everything gathered so far without any pulse.
               if (cfg_start) begin
                  cnt    <= '0;
                  shadow <= '0;
               end else if (cfg_valid) begin
                  shadow <= {shadow[FRAME-2:0], cfg_din};
                  cnt    <= cnt + 1'b1;
                  if (last_bit) state <= CHECK;
               end
            end
            CHECK: begin
               state    <= IDLE;
               cfg_busy <= 1'b0;
               if (frame_bad) begin
                  cfg_err <= 1'b1;
               end else begin
                  cfg_bus  <= frame_data;
                  cfg_done <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               cfg_busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_switch_config_loader.sv
// Randomized bench for switch_config_loader against a word-level reference model.
module tb_switch_config_loader;
   localparam int W_TB   = 5;
   localparam int W_LR   = 4;
   localparam int WORD_W = 6;
   localparam int NWORDS = 2*W_TB + 2*W_LR;
   localparam int TOTAL  = NWORDS*WORD_W;
`ifdef PARITY_CHECK_EN
   localparam int FRAME  = TOTAL + 1;
`else
   localparam int FRAME  = TOTAL;
`endif

   logic clk = 1'b0;
   logic rst_n, cfg_start, cfg_din, cfg_valid, cfg_clear;
   logic [TOTAL-1:0] cfg_bus;
   logic cfg_busy, cfg_done, cfg_err;

   switch_config_loader #(.W_TB(W_TB), .W_LR(W_LR), .WORD_W(WORD_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_din(cfg_din),
      .cfg_valid(cfg_valid), .cfg_clear(cfg_clear), .cfg_bus(cfg_bus),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   logic [5:0]       frame_w [NWORDS];
   logic [TOTAL-1:0] frame_vec;
   logic [TOTAL-1:0] model_bus;

   always @(negedge clk) begin
      if (cfg_done) done_cnt++;
      if (cfg_err)  err_cnt++;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit word_ok(input logic [5:0] w);
      int code = int'(w[2:0]);
      int idx  = int'(w[5:3]);
      if (code == 0) return 1'b1;
      if (code == 1 || code == 3) return idx < W_TB;
      if (code == 2 || code == 4) return idx < W_LR;
      return 1'b0;
   endfunction

   function automatic bit frame_ok();
      for (int k = 0; k < NWORDS; k++)
         if (!word_ok(frame_w[k])) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [5:0] rand_good_word();
      int code = $urandom_range(0, 4);
      int lim  = (code == 1 || code == 3) ? W_TB : W_LR;
      logic [2:0] c = 3'(code);
      logic [2:0] i = 3'($urandom_range(0, lim-1));
      if (code == 0) i = 3'($urandom_range(0, 7));
      return {i, c};
   endfunction

   function automatic logic [5:0] rand_bad_word();
      logic [2:0] c;
      case ($urandom_range(0, 2))
         0: return {3'($urandom_range(0, 7)), 3'($urandom_range(5, 7))};
         1: begin
            c = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd3;
            return {3'($urandom_range(W_TB, 7)), c};
         end
         default: begin
            c = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd4;
            return {3'($urandom_range(W_LR, 7)), c};
         end
      endcase
   endfunction

   task automatic gen_frame(input bit make_bad);
      for (int k = 0; k < NWORDS; k++) frame_w[k] = rand_good_word();
      if (make_bad) frame_w[$urandom_range(0, NWORDS-1)] = rand_bad_word();
   endtask

   task automatic pack();
      for (int k = 0; k < NWORDS; k++) frame_vec[k*6 +: 6] = frame_w[k];
   endtask

   // Stream order: data MSB first (bit 107 first), then the even-parity bit if enabled.
   function automatic logic stream_bit(input int i, input bit flip);
      if (i < TOTAL) return frame_vec[TOTAL-1-i];
      return (^frame_vec) ^ flip;
   endfunction

   task automatic begin_frame();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      chk("busy_after_start", cfg_busy, 1'b1);
   endtask

   task automatic shift_bits(input int from, input int to, input bit gapped, input bit flip);
      for (int i = from; i <= to; i++) begin
         if (gapped) begin
            cfg_valid = 1'b0;
            cfg_din   = 1'($urandom_range(0, 1));
            step();
         end
         cfg_valid = 1'b1;
         cfg_din   = stream_bit(i, flip);
         step();
         if (i == 50) chk("bus_hidden_mid_load", cfg_bus, model_bus);
      end
      cfg_valid = 1'b0;
   endtask

   task automatic finish_frame(input bit flip, input bit start_in_check);
      bit ok = frame_ok() && !flip;
      chk("busy_in_check", cfg_busy, 1'b1);
      chk("no_done_early", cfg_done, 1'b0);
      if (start_in_check) cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      chk("done_pulse", cfg_done, ok);
      chk("err_pulse", cfg_err, !ok);
      if (ok) model_bus = frame_vec;
      chk("bus_after_check", cfg_bus, model_bus);
      chk("busy_after_check", cfg_busy, 1'b0);
      step();
      chk("done_one_cycle", cfg_done, 1'b0);
      chk("err_one_cycle", cfg_err, 1'b0);
      chk("idle_after_check", cfg_busy, 1'b0);
   endtask

   task automatic run_frame(input bit gapped, input bit flip, input bit start_in_check);
      pack();
      begin_frame();
      shift_bits(0, FRAME-1, gapped, flip);
      finish_frame(flip, start_in_check);
   endtask

   initial begin
      int d0, e0;
      rst_n = 1'b0; cfg_start = 1'b0; cfg_din = 1'b0; cfg_valid = 1'b0; cfg_clear = 1'b0;
      model_bus = '0;
      #12;
      chk("reset_bus", cfg_bus, '0);
      chk("reset_busy", cfg_busy, 1'b0);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("idle_bus", cfg_bus, '0);
         chk("idle_flags", {cfg_busy, cfg_done, cfg_err}, 3'b000);
      end

      for (int c = 0; c < 10; c++) begin
         cfg_valid = 1'b1;
         cfg_din   = 1'($urandom_range(0, 1));
         step();
      end
      cfg_valid = 1'b0;
      chk("valid_ignored_in_idle", {cfg_busy, cfg_done, cfg_err}, 3'b000);
      chk("valid_ignored_bus", cfg_bus, '0);

      for (int k = 0; k < NWORDS; k++) frame_w[k] = 6'd0;
      frame_w[0] = 6'b000_011;
      run_frame(1'b0, 1'b0, 1'b0);
      chk("directed_word0", cfg_bus[5:0], 6'b000011);
      chk("directed_rest_zero", cfg_bus[TOTAL-1:6], '0);

      gen_frame(1'b0);
      frame_w[16] = 6'b000_110;
      d0 = done_cnt;
      run_frame(1'b0, 1'b0, 1'b0);
      chk("bad_side_no_done", done_cnt - d0, 0);

      d0 = done_cnt; e0 = err_cnt;
      gen_frame(1'b0);
      pack();
      begin_frame();
      shift_bits(0, 49, 1'b0, 1'b0);
      gen_frame(1'b0);
      run_frame(1'b0, 1'b0, 1'b0);
      chk("restart_one_done", done_cnt - d0, 1);
      chk("restart_no_err", err_cnt - e0, 0);

      gen_frame(1'b0);
      pack();
      begin_frame();
      shift_bits(0, 9, 1'b0, 1'b0);
      cfg_clear = 1'b1;
      step();
      cfg_clear = 1'b0;
      chk("clear_ignored_busy", cfg_bus, model_bus);
      shift_bits(10, FRAME-1, 1'b0, 1'b0);
      finish_frame(1'b0, 1'b0);

      gen_frame(1'b0);
      run_frame(1'b0, 1'b0, 1'b1);

      d0 = done_cnt; e0 = err_cnt;
      gen_frame(1'b0);
      pack();
      begin_frame();
      shift_bits(0, 59, 1'b1, 1'b0);
      rst_n = 1'b0;
      #2;
      model_bus = '0;
      chk("midreset_bus", cfg_bus, model_bus);
      chk("midreset_flags", {cfg_busy, cfg_done, cfg_err}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      chk("midreset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      gen_frame(1'b0);
      run_frame(1'b0, 1'b0, 1'b0);
      chk("after_reset_commit", done_cnt - d0, 1);

`ifdef PARITY_CHECK_EN
      gen_frame(1'b0);
      run_frame(1'b0, 1'b1, 1'b0);
      run_frame(1'b0, 1'b0, 1'b0);
`endif

      cfg_clear = 1'b1;
      cfg_start = 1'b1;
      step();
      cfg_clear = 1'b0;
      cfg_start = 1'b0;
      model_bus = '0;
      chk("clear_bus", cfg_bus, model_bus);
      chk("clear_drops_start", cfg_busy, 1'b0);

      for (int n = 0; n < 25; n++) begin
         gen_frame($urandom_range(0, 2) == 0);
         run_frame(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
